// File: rtl/motion_frame_ctrl.sv
// Frame sequencer for background subtraction: admits one frame of reads per start, then waits for all mask writes.
// Read strobes and empty gating are zero-latency; frame_done comes one cycle after the last write is seen.
module motion_frame_ctrl #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540,
    parameter int CNT_W  = 20,
    parameter int DATA_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  threshold,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  motion_count,
    output logic              motion_flag,
    output logic              protocol_err,
    input  logic              bg_empty,
    input  logic              fr_empty,
    output logic              bg_rd_en,
    output logic              fr_rd_en,
    output logic              sub_bg_empty,
    output logic              sub_fr_empty,
    input  logic              sub_bg_rd_en,
    input  logic              sub_fr_rd_en,
    input  logic              sub_out_wr_en,
    input  logic [DATA_W-1:0] sub_out_din,
    input  logic              out_full
);
    localparam int               PIXELS   = WIDTH * HEIGHT;
    localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(PIXELS);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, mot_cnt, thr_q;
    logic             gate, accept, rd_pair, rd_any, rd_full, wr_full, err_now;
    logic             unused_out_full;

    assign rd_pair = sub_bg_rd_en & sub_fr_rd_en;
    assign rd_any  = sub_bg_rd_en | sub_fr_rd_en;
    assign rd_full = (rd_cnt == PIX_MAX);
    assign wr_full = (wr_cnt == PIX_MAX);

    always_comb begin
        state_nxt = state;
        gate      = 1'b1;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                gate = rd_full;
                if (rd_full || (rd_pair && rd_cnt == PIX_LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (wr_full) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Writes into a full frame or outside a frame are flagged but never counted past PIXELS.
    assign err_now = (sub_bg_rd_en ^ sub_fr_rd_en)
                   | (rd_any & gate)
                   | (sub_out_wr_en & (wr_full | (state == IDLE)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            mot_cnt      <= '0;
            thr_q        <= '0;
            motion_count <= '0;
            motion_flag  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                thr_q   <= threshold;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
                mot_cnt <= '0;
            end else begin
                if (state == RUN && rd_pair && !rd_full) rd_cnt <= rd_cnt + CNT_ONE;
                if (sub_out_wr_en && !wr_full) begin
                    wr_cnt <= wr_cnt + CNT_ONE;
                    if (sub_out_din != '0) mot_cnt <= mot_cnt + CNT_ONE;
                end
            end
            if (state == DONE) begin
                motion_count <= mot_cnt;
                motion_flag  <= (mot_cnt >= thr_q);
            end
            if (err_now) protocol_err <= 1'b1;
        end
    end

    assign busy         = (state != IDLE);
    assign frame_done   = (state == DONE);
    assign sub_bg_empty = bg_empty | gate;
    assign sub_fr_empty = fr_empty | gate;
    assign bg_rd_en     = sub_bg_rd_en;
    assign fr_rd_en     = sub_fr_rd_en;

    // Mask-FIFO backpressure goes straight to subtract at the integrating level.
    assign unused_out_full = out_full;

endmodule

// File: tb/tb_motion_frame_ctrl.sv
// Bench for motion_frame_ctrl: emulates subtract and the FIFOs on a 4x2 frame, checks frame verdicts
// from a table of vectors and from random frames against a simple pixel-count model.
module tb_motion_frame_ctrl;
    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 2;
    localparam int PIXELS  = WIDTH * HEIGHT;
    localparam int CNT_W   = 4;
    localparam int DATA_W  = 24;
    localparam int MAX_CYC = 400;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  threshold = '0;
    logic              busy, frame_done, motion_flag, protocol_err;
    logic [CNT_W-1:0]  motion_count;
    logic              bg_empty = 1'b0, fr_empty = 1'b0;
    logic              bg_rd_en, fr_rd_en, sub_bg_empty, sub_fr_empty;
    logic              sub_bg_rd_en = 1'b0, sub_fr_rd_en = 1'b0, sub_out_wr_en = 1'b0;
    logic [DATA_W-1:0] sub_out_din = '0;
    logic              out_full = 1'b0;

    motion_frame_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .start(start), .threshold(threshold),
        .busy(busy), .frame_done(frame_done), .motion_count(motion_count),
        .motion_flag(motion_flag), .protocol_err(protocol_err),
        .bg_empty(bg_empty), .fr_empty(fr_empty), .bg_rd_en(bg_rd_en), .fr_rd_en(fr_rd_en),
        .sub_bg_empty(sub_bg_empty), .sub_fr_empty(sub_fr_empty),
        .sub_bg_rd_en(sub_bg_rd_en), .sub_fr_rd_en(sub_fr_rd_en),
        .sub_out_wr_en(sub_out_wr_en), .sub_out_din(sub_out_din), .out_full(out_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CNT_W-1:0]  thr;
        logic [PIXELS-1:0] nz;
        int                exp_cnt;
        int                exp_flag;
    } vec_t;

    int                tests = 0;
    int                fails = 0;
    logic [DATA_W-1:0] frame_pix [PIXELS];
    int                model_count = 0;
    int                model_flag  = 0;
    bit                rand_empty  = 1'b0;
    int                gate_bad    = 0;
    vec_t              vecs [8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_count = 0;
        model_flag  = 0;
    endtask

    task automatic load_frame(input logic [PIXELS-1:0] nz);
        for (int i = 0; i < PIXELS; i++)
            frame_pix[i] = nz[i] ? DATA_W'($urandom_range(1, 16777215)) : '0;
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < PIXELS; i++)
            if (frame_pix[i] != 0) n++;
        return n;
    endfunction

    // Plays subtract: reads pairs while ungated, writes the mask later in read order.
    task automatic run_frame(input logic [CNT_W-1:0] thr, input int stall, input int full_at,
                             input int full_len, input bit start_mid,
                             output int n_reads, output int n_done, output int busy_bad);
        logic [DATA_W-1:0] q [$];
        int cyc, after;
        n_reads = 0; n_done = 0; busy_bad = 0; cyc = 0; after = 0;
        start = 1'b1;
        threshold = thr;
        step();
        start = 1'b0;
        threshold = CNT_W'($urandom);
        check("count_hold", int'(motion_count), model_count);
        check("flag_hold", int'(motion_flag), model_flag);
        while (after < 3 && cyc < MAX_CYC) begin
            start = (start_mid && cyc == 5);
            if (rand_empty) begin
                bg_empty = ($urandom_range(3) == 0);
                fr_empty = ($urandom_range(3) == 0);
            end
            out_full = (cyc >= full_at && cyc < full_at + full_len);
            #1;
            if (bg_empty && !sub_bg_empty) gate_bad++;
            if (fr_empty && !sub_fr_empty) gate_bad++;
            sub_bg_rd_en = 1'b0; sub_fr_rd_en = 1'b0; sub_out_wr_en = 1'b0; sub_out_din = '0;
            if (q.size() > 0 && !out_full && $urandom_range(99) >= stall) begin
                sub_out_wr_en = 1'b1;
                sub_out_din   = q.pop_front();
            end
            if (!sub_bg_empty && !sub_fr_empty && $urandom_range(99) >= stall) begin
                sub_bg_rd_en = 1'b1;
                sub_fr_rd_en = 1'b1;
                q.push_back(n_reads < PIXELS ? frame_pix[n_reads] : '0);
                n_reads++;
            end
            @(negedge clock);
            if (frame_done) n_done++;
            if (n_done == 0 && !busy) busy_bad++;
            if (n_done > 0) after++;
            step();
            cyc++;
        end
        sub_bg_rd_en = 1'b0; sub_fr_rd_en = 1'b0; sub_out_wr_en = 1'b0; sub_out_din = '0;
        bg_empty = 1'b0; fr_empty = 1'b0; out_full = 1'b0; start = 1'b0;
        check("frame_timeout", int'(cyc >= MAX_CYC), 0);
    endtask

    task automatic frame_and_check(input string tag, input logic [CNT_W-1:0] thr, input int stall,
                                   input int full_at, input int full_len, input bit start_mid,
                                   input int exp_cnt, input int exp_flag);
        int n_reads, n_done, busy_bad;
        run_frame(thr, stall, full_at, full_len, start_mid, n_reads, n_done, busy_bad);
        @(negedge clock);
        check({tag, "_reads"}, n_reads, PIXELS);
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_busy_drop"}, busy_bad, 0);
        check({tag, "_count"}, int'(motion_count), exp_cnt);
        check({tag, "_flag"}, int'(motion_flag), exp_flag);
        check({tag, "_gated_idle"}, int'(sub_bg_empty & sub_fr_empty), 1);
        check({tag, "_busy_idle"}, int'(busy), 0);
        check({tag, "_no_err"}, int'(protocol_err), 0);
        model_count = exp_cnt;
        model_flag  = exp_flag;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_gate, bad_busy, bad_rd, bad_out;
        vecs[0] = '{4'd3,  8'b1011_0101, 5, 1};
        vecs[1] = '{4'd6,  8'b1011_0101, 5, 0};
        vecs[2] = '{4'd0,  8'h00,        0, 1};
        vecs[3] = '{4'd8,  8'hff,        8, 1};
        vecs[4] = '{4'd9,  8'hff,        8, 0};
        vecs[5] = '{4'd15, 8'h01,        1, 0};
        vecs[6] = '{4'd1,  8'h80,        1, 1};
        vecs[7] = '{4'd5,  8'h1f,        5, 1};

        // Reset state with non-empty FIFOs: nothing may leak through.
        do_reset();
        bad_gate = 0; bad_busy = 0; bad_rd = 0; bad_out = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!sub_bg_empty || !sub_fr_empty) bad_gate++;
            if (busy || frame_done) bad_busy++;
            if (bg_rd_en || fr_rd_en) bad_rd++;
            if (motion_count != 0 || motion_flag || protocol_err) bad_out++;
        end
        check("rst_gate", bad_gate, 0);
        check("rst_busy", bad_busy, 0);
        check("rst_reads", bad_rd, 0);
        check("rst_outputs", bad_out, 0);
        step();

        for (int i = 0; i < 8; i++) begin
            load_frame(vecs[i].nz);
            frame_and_check($sformatf("vec%0d", i), vecs[i].thr, 0, -1, 0, 1'b0,
                            vecs[i].exp_cnt, vecs[i].exp_flag);
        end

        load_frame(8'b1011_0101);
        frame_and_check("full_hold", 4'd3, 0, 6, 30, 1'b0, 5, 1);

        load_frame(8'h0f);
        frame_and_check("start_mid", 4'd4, 20, -1, 0, 1'b1, 4, 1);

        rand_empty = 1'b1;
        for (int r = 0; r < 20; r++) begin
            logic [CNT_W-1:0] thr;
            int exp;
            thr = CNT_W'($urandom_range(0, 10));
            load_frame(PIXELS'($urandom));
            exp = model_cnt();
            frame_and_check($sformatf("rnd%0d", r), thr, int'($urandom_range(0, 60)), -1, 0, 1'b0,
                            exp, int'(exp >= int'(thr)));
        end
        rand_empty = 1'b0;
        check("gating_violations", gate_bad, 0);

        // Reset in the middle of a frame, then a clean frame.
        load_frame(8'hff);
        start = 1'b1; threshold = 4'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sub_bg_rd_en = 1'b1; sub_fr_rd_en = 1'b1;
            sub_out_wr_en = 1'b1; sub_out_din = frame_pix[i];
            step();
        end
        sub_bg_rd_en = 1'b0; sub_fr_rd_en = 1'b0; sub_out_wr_en = 1'b0; sub_out_din = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_count = 0; model_flag = 0;
        @(negedge clock);
        check("midrst_busy", int'(busy), 0);
        check("midrst_gate", int'(sub_bg_empty & sub_fr_empty), 1);
        check("midrst_count", int'(motion_count), 0);
        check("midrst_flag", int'(motion_flag), 0);
        step();
        load_frame(vecs[0].nz);
        frame_and_check("after_midrst", vecs[0].thr, 10, -1, 0, 1'b0, vecs[0].exp_cnt, vecs[0].exp_flag);

        // Start coincident with reset is dropped.
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        model_count = 0; model_flag = 0;
        @(negedge clock);
        check("rst_start_busy0", int'(busy), 0);
        step();
        @(negedge clock);
        check("rst_start_busy1", int'(busy), 0);
        step();

        // Protocol errors: unpaired read, sticky until reset.
        sub_bg_rd_en = 1'b1;
        #1;
        check("bg_rd_passthru", int'(bg_rd_en), 1);
        check("fr_rd_passthru", int'(fr_rd_en), 0);
        step();
        sub_bg_rd_en = 1'b0;
        @(negedge clock);
        check("err_rd_mismatch", int'(protocol_err), 1);
        repeat (5) step();
        @(negedge clock);
        check("err_sticky", int'(protocol_err), 1);
        step();
        do_reset();
        @(negedge clock);
        check("err_cleared", int'(protocol_err), 0);
        step();

        sub_out_wr_en = 1'b1; sub_out_din = 24'h5;
        step();
        sub_out_wr_en = 1'b0; sub_out_din = '0;
        @(negedge clock);
        check("err_idle_write", int'(protocol_err), 1);
        step();
        do_reset();

        sub_bg_rd_en = 1'b1; sub_fr_rd_en = 1'b1;
        step();
        sub_bg_rd_en = 1'b0; sub_fr_rd_en = 1'b0;
        @(negedge clock);
        check("err_gated_read", int'(protocol_err), 1);
        step();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
